// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch / countdown core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2,
    EXPIRED = 2'd3
  } sw_state_e;

  localparam logic [7:0] CS_MAX  = 8'd99;
  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [7:0] cs;
  } sw_time_t;

  // Lap word layout seen by the display/UART side: {h, m, s, cs}.
  function automatic logic [31:0] pack_time(input sw_time_t t);
    return {t.h, t.m, t.s, t.cs};
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word fall-through FIFO for lap captures, with synchronous flush.
module lap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count_nxt;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
  end

  // Storage, pointers (wrap naturally, depth is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch / countdown core: hh:mm:ss:cc counter, run/stop/expire FSM,
// countdown preset with field adjust, and a lap capture FIFO.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int HOUR_MAX       = 99,
  parameter int LAP_DEPTH      = 8,
  parameter int CD_DEFAULT_MIN = 1
) (
  input  logic                             clk_100Hz,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             clear,
  input  logic                             lap,
  input  logic                             sec_inc,
  input  logic                             min_inc,
  input  logic                             hour_inc,
  input  logic                             countdown_mode,
  input  logic                             lap_rd,
  output logic [7:0]                       hours,
  output logic [7:0]                       minutes,
  output logic [7:0]                       seconds,
  output logic [7:0]                       centisec,
  output logic                             running,
  output logic                             expired,
  output logic                             lap_valid,
  output logic [31:0]                      lap_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_overflow
);
  localparam int         LCW  = $clog2(LAP_DEPTH + 1);
  localparam logic [7:0] HMAX = 8'(HOUR_MAX);
  localparam sw_time_t   PRESET_RST = '{h: 8'd0, m: 8'(CD_DEFAULT_MIN), s: 8'd0, cs: 8'd0};

  sw_state_e state;
  sw_time_t  live, preset, t_up, t_dn, t_adj;
  logic      mode_prev, mode_edge, live_zero, start_ok, adj_ok;
  logic      lap_push, lap_full;

  assign mode_edge = (countdown_mode != mode_prev);
  assign live_zero = (live == '0);
  // Countdown with nothing left cannot be started; EXPIRED needs an adjust first.
  assign start_ok  = start && (state != RUNNING) && !(countdown_mode && live_zero);
  assign adj_ok    = countdown_mode && (state != RUNNING) && (sec_inc || min_inc || hour_inc);
  assign lap_push  = lap && (state == RUNNING);

  assign hours    = live.h;
  assign minutes  = live.m;
  assign seconds  = live.s;
  assign centisec = live.cs;

  // Count-up successor with carry chain and hour wrap.
  always_comb begin
    t_up = live;
    if (live.cs == CS_MAX) begin
      t_up.cs = '0;
      if (live.s == SEC_MAX) begin
        t_up.s = '0;
        if (live.m == MIN_MAX) begin
          t_up.m = '0;
          t_up.h = (live.h == HMAX) ? '0 : live.h + 8'd1;
        end else t_up.m = live.m + 8'd1;
      end else t_up.s = live.s + 8'd1;
    end else t_up.cs = live.cs + 8'd1;
  end

  // Countdown predecessor with borrow chain; only used when live is non-zero.
  always_comb begin
    t_dn = live;
    if (live.cs != '0) t_dn.cs = live.cs - 8'd1;
    else begin
      t_dn.cs = CS_MAX;
      if (live.s != '0) t_dn.s = live.s - 8'd1;
      else begin
        t_dn.s = SEC_MAX;
        if (live.m != '0) t_dn.m = live.m - 8'd1;
        else begin
          t_dn.m = MIN_MAX;
          t_dn.h = live.h - 8'd1;
        end
      end
    end
  end

  // Independent per-field adjust, no carry between fields.
  always_comb begin
    t_adj = live;
    if (sec_inc)  t_adj.s = (live.s == SEC_MAX) ? '0 : live.s + 8'd1;
    if (min_inc)  t_adj.m = (live.m == MIN_MAX) ? '0 : live.m + 8'd1;
    if (hour_inc) t_adj.h = (live.h == HMAX)    ? '0 : live.h + 8'd1;
  end

  // Main FSM and time register: one action per cycle in priority order.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      expired   <= 1'b0;
      live      <= '0;
      preset    <= PRESET_RST;
      mode_prev <= 1'b0;
    end else begin
      mode_prev <= countdown_mode;
      expired   <= 1'b0;
      if (clear || mode_edge) begin
        state   <= IDLE;
        running <= 1'b0;
        live    <= countdown_mode ? preset : '0;
      end else if (stop && state == RUNNING) begin
        state   <= STOPPED;
        running <= 1'b0;
      end else if (start_ok) begin
        state   <= RUNNING;
        running <= 1'b1;
      end else if (adj_ok) begin
        live <= t_adj;
        if (state == IDLE) preset <= t_adj;
      end else if (state == RUNNING) begin
        if (!countdown_mode) live <= t_up;
        else if (live_zero) begin
          state   <= EXPIRED;
          running <= 1'b0;
          expired <= 1'b1;
        end else live <= t_dn;
      end
    end
  end

  // Sticky drop flag: a lap hit a full FIFO with no same-cycle pop.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n)     lap_overflow <= 1'b0;
    else if (clear) lap_overflow <= 1'b0;
    else if (lap_push && lap_full && !(lap_rd && lap_valid)) lap_overflow <= 1'b1;
  end

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (32),
    .CW    (LCW)
  ) u_lap_fifo (
    .clk   (clk_100Hz),
    .rst_n (rst_n),
    .flush (clear),
    .push  (lap_push),
    .pop   (lap_rd),
    .din   (pack_time(live)),
    .dout  (lap_data),
    .count (lap_count),
    .valid (lap_valid),
    .full  (lap_full)
  );

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: table vectors, corner sequences, random run
// against a total-centisecond reference model.
module tb_stopwatch_lap_timer;
  localparam int HMAX  = 2;
  localparam int DEPTH = 4;
  localparam int CDMIN = 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WRAP  = (HMAX + 1) * 360000;

  // Input vector bits: {start, stop, clear, lap, sec, min, hour, mode, rd}
  localparam logic [8:0] NO = 9'h000, ST = 9'h100, SP = 9'h080, CL = 9'h040, LP = 9'h020;
  localparam logic [8:0] SI = 9'h010, MI = 9'h008, HI = 9'h004, MD = 9'h002, RD = 9'h001;

  logic clk_100Hz = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, clear = 0, lap = 0, sec_inc = 0, min_inc = 0, hour_inc = 0;
  logic countdown_mode = 0, lap_rd = 0;
  logic [7:0] hours, minutes, seconds, centisec;
  logic running, expired, lap_valid, lap_overflow;
  logic [31:0] lap_data;
  logic [CW-1:0] lap_count;

  int checks = 0, errors = 0, cyc_n = 0;

  stopwatch_lap_timer #(.HOUR_MAX(HMAX), .LAP_DEPTH(DEPTH), .CD_DEFAULT_MIN(CDMIN)) dut (
    .clk_100Hz(clk_100Hz), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .sec_inc(sec_inc), .min_inc(min_inc), .hour_inc(hour_inc),
    .countdown_mode(countdown_mode), .lap_rd(lap_rd), .hours(hours), .minutes(minutes),
    .seconds(seconds), .centisec(centisec), .running(running), .expired(expired),
    .lap_valid(lap_valid), .lap_data(lap_data), .lap_count(lap_count),
    .lap_overflow(lap_overflow));

  always #5 clk_100Hz = ~clk_100Hz;

  // ---------------- reference model: time as a total centisecond count ----
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_EXP = 3;
  int          m_st, m_tot, m_pre;
  bit          m_mprev, m_exp, m_ovf;
  logic [31:0] m_q[$];

  function automatic logic [31:0] tword(input int t);
    return {8'(t / 360000), 8'((t / 6000) % 60), 8'((t / 100) % 60), 8'(t % 100)};
  endfunction

  task automatic m_reset();
    m_st = M_IDLE; m_tot = 0; m_pre = CDMIN * 6000;
    m_mprev = 0; m_exp = 0; m_ovf = 0; m_q.delete();
  endtask

  task automatic m_step(input logic [8:0] v);
    logic i_st, i_sp, i_cl, i_lp, i_si, i_mi, i_hi, i_md, i_rd;
    int h, mi, s, c;
    logic [31:0] w;
    bit was_run;
    {i_st, i_sp, i_cl, i_lp, i_si, i_mi, i_hi, i_md, i_rd} = v;
    w = tword(m_tot);
    was_run = (m_st == M_RUN);
    if (i_cl) begin
      m_q.delete(); m_ovf = 0;
    end else begin
      if (i_rd && m_q.size() > 0) void'(m_q.pop_front());
      if (i_lp && was_run) begin
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1;
      end
    end
    m_exp = 0;
    if (i_cl || i_md != m_mprev) begin
      m_st = M_IDLE; m_tot = i_md ? m_pre : 0;
    end else if (i_sp && m_st == M_RUN) m_st = M_STOP;
    else if (i_st && m_st != M_RUN && !(i_md && m_tot == 0)) m_st = M_RUN;
    else if (i_md && m_st != M_RUN && (i_si || i_mi || i_hi)) begin
      h = m_tot / 360000; mi = (m_tot / 6000) % 60; s = (m_tot / 100) % 60; c = m_tot % 100;
      if (i_si) s = (s + 1) % 60;
      if (i_mi) mi = (mi + 1) % 60;
      if (i_hi) h = (h + 1) % (HMAX + 1);
      m_tot = h * 360000 + mi * 6000 + s * 100 + c;
      if (m_st == M_IDLE) m_pre = m_tot;
    end else if (m_st == M_RUN) begin
      if (!i_md) m_tot = (m_tot + 1) % WRAP;
      else if (m_tot == 0) begin m_st = M_EXP; m_exp = 1; end
      else m_tot = m_tot - 1;
    end
    m_mprev = i_md;
  endtask

  // ---------------- checking helpers ---------------------------------------
  task automatic chk_model();
    logic [39:0] act, exp_v;
    act   = {hours, minutes, seconds, centisec, running, expired, lap_valid, lap_overflow, 4'(lap_count)};
    exp_v = {tword(m_tot), m_st == M_RUN, m_exp, m_q.size() != 0, m_ovf, 4'(m_q.size())};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model cyc %0d: got %h, want %h", cyc_n, act, exp_v);
    end
    if (m_q.size() > 0) begin
      checks++;
      if (lap_data !== m_q[0]) begin
        errors++;
        $display("FAIL lap_data cyc %0d: got %h, want %h", cyc_n, lap_data, m_q[0]);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp_v);
    end
  endtask

  task automatic expect_t(input string nm, input logic [31:0] t, input logic run, input logic ex);
    chk({nm, " time"}, {hours, minutes, seconds, centisec}, t);
    chk({nm, " run/exp"}, {30'd0, running, expired}, {30'd0, run, ex});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " time"}, {hours, minutes, seconds, centisec}, 32'h0);
    chk({nm, " flags"}, {26'd0, running, expired, lap_valid, lap_overflow, 2'(lap_count != 0)}, 32'h0);
    chk({nm, " lap_data"}, lap_data, 32'h0);
  endtask

  // Drive one cycle of inputs just after a negedge, step the model, sample at next negedge.
  task automatic cyc(input logic [8:0] v);
    {start, stop, clear, lap, sec_inc, min_inc, hour_inc, countdown_mode, lap_rd} = v;
    m_step(v);
    @(posedge clk_100Hz);
    @(negedge clk_100Hz);
    cyc_n++;
    chk_model();
  endtask

  task automatic do_reset();
    {start, stop, clear, lap, sec_inc, min_inc, hour_inc, countdown_mode, lap_rd} = '0;
    rst_n = 1'b0;
    @(negedge clk_100Hz);
    chk_zero("reset");
    m_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic [8:0]  in;
    logic [31:0] t;
    logic        run;
    logic        ex;
    int          cnt;
  } vec_t;
  vec_t tbl[21];

  initial begin
    logic [8:0] v;
    bit md;

    tbl[0]  = '{NO,           32'h00000000, 1'b0, 1'b0, 0};
    tbl[1]  = '{ST,           32'h00000000, 1'b1, 1'b0, 0};
    tbl[2]  = '{NO,           32'h00000001, 1'b1, 1'b0, 0};
    tbl[3]  = '{NO,           32'h00000002, 1'b1, 1'b0, 0};
    tbl[4]  = '{LP,           32'h00000003, 1'b1, 1'b0, 1};
    tbl[5]  = '{ST|SP,        32'h00000003, 1'b0, 1'b0, 1};
    tbl[6]  = '{NO,           32'h00000003, 1'b0, 1'b0, 1};
    tbl[7]  = '{SI,           32'h00000003, 1'b0, 1'b0, 1};
    tbl[8]  = '{ST,           32'h00000003, 1'b1, 1'b0, 1};
    tbl[9]  = '{NO,           32'h00000004, 1'b1, 1'b0, 1};
    tbl[10] = '{MD,           32'h00010000, 1'b0, 1'b0, 1};
    tbl[11] = '{MD|HI,        32'h01010000, 1'b0, 1'b0, 1};
    tbl[12] = '{MD|HI,        32'h02010000, 1'b0, 1'b0, 1};
    tbl[13] = '{MD|HI,        32'h00010000, 1'b0, 1'b0, 1};
    tbl[14] = '{MD|SI|MI|HI,  32'h01020100, 1'b0, 1'b0, 1};
    tbl[15] = '{MD|ST,        32'h01020100, 1'b1, 1'b0, 1};
    tbl[16] = '{MD,           32'h01020063, 1'b1, 1'b0, 1};
    tbl[17] = '{MD|SP,        32'h01020063, 1'b0, 1'b0, 1};
    tbl[18] = '{MD|CL,        32'h01020100, 1'b0, 1'b0, 0};
    tbl[19] = '{MD|RD,        32'h01020100, 1'b0, 1'b0, 0};
    tbl[20] = '{NO,           32'h00000000, 1'b0, 1'b0, 0};

    #3;
    chk_zero("por");
    do_reset();

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].in);
      expect_t($sformatf("vec%0d", i), tbl[i].t, tbl[i].run, tbl[i].ex);
      chk($sformatf("vec%0d count", i), 32'(lap_count), 32'(tbl[i].cnt));
    end

    // Count-up: one minute, then start+stop together stops and holds.
    do_reset();
    cyc(ST);
    repeat (6000) cyc(NO);
    expect_t("up 1min", 32'h00010000, 1'b1, 1'b0);
    cyc(ST|SP);
    expect_t("up start+stop", 32'h00010000, 1'b0, 1'b0);
    cyc(NO);
    expect_t("up hold", 32'h00010000, 1'b0, 1'b0);

    // Countdown to zero, expire pulse, start ignored, adjust then restart.
    do_reset();
    cyc(MD);
    expect_t("cd load", 32'h00010000, 1'b0, 1'b0);
    cyc(MD|ST);
    repeat (5997) cyc(MD);
    expect_t("cd 03", 32'h00000003, 1'b1, 1'b0);
    cyc(MD); expect_t("cd 02", 32'h00000002, 1'b1, 1'b0);
    cyc(MD); expect_t("cd 01", 32'h00000001, 1'b1, 1'b0);
    cyc(MD); expect_t("cd 00", 32'h00000000, 1'b1, 1'b0);
    cyc(MD); expect_t("cd expire", 32'h00000000, 1'b0, 1'b1);
    cyc(MD); expect_t("cd pulse end", 32'h00000000, 1'b0, 1'b0);
    cyc(MD|ST); expect_t("cd start ignored", 32'h00000000, 1'b0, 1'b0);
    cyc(MD|SP); expect_t("cd stop no effect", 32'h00000000, 1'b0, 1'b0);
    cyc(MD|SI); expect_t("cd adj expired", 32'h00000100, 1'b0, 1'b0);
    cyc(MD|ST); expect_t("cd restart", 32'h00000100, 1'b1, 1'b0);
    cyc(MD);    expect_t("cd borrow", 32'h00000063, 1'b1, 1'b0);

    // Borrow across seconds into minutes with non-zero hours.
    do_reset();
    cyc(MD); cyc(MD|HI); cyc(MD|ST); cyc(MD);
    expect_t("cd borrow min", 32'h01003B63, 1'b1, 1'b0);

    // Preset adjust in IDLE survives run/stop/clear.
    do_reset();
    cyc(MD);
    repeat (4) cyc(MD|MI);
    expect_t("preset set", 32'h00050000, 1'b0, 1'b0);
    cyc(MD|ST);
    repeat (150) cyc(MD);
    expect_t("preset run", 32'h00043A32, 1'b1, 1'b0);
    cyc(MD|SP);
    expect_t("preset stop", 32'h00043A32, 1'b0, 1'b0);
    cyc(MD|CL);
    expect_t("preset clear", 32'h00050000, 1'b0, 1'b0);

    // Laps at cs 10..50 into a 4-deep FIFO: fifth is dropped.
    do_reset();
    cyc(ST);
    repeat (10) cyc(NO);
    for (int k = 0; k < 5; k++) begin
      cyc(LP);
      if (k < 4) repeat (9) cyc(NO);
    end
    chk("lap count full", 32'(lap_count), 32'd4);
    chk("lap overflow", {31'd0, lap_overflow}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lap head %0d", k), lap_data, 32'(10 * (k + 1)));
      cyc(RD);
    end
    chk("lap drained", {31'd0, lap_valid}, 32'd0);

    // Fifth lap together with a pop is accepted.
    cyc(CL);
    chk("clear ovf", {31'd0, lap_overflow}, 32'd0);
    cyc(ST);
    repeat (10) cyc(NO);
    for (int k = 0; k < 4; k++) begin
      cyc(LP);
      repeat (9) cyc(NO);
    end
    cyc(LP|RD);
    chk("lap+rd count", 32'(lap_count), 32'd4);
    chk("lap+rd ovf", {31'd0, lap_overflow}, 32'd0);
    chk("lap+rd head", lap_data, 32'd20);

    // Async reset mid-run in countdown mode, then preset reload on first edge.
    do_reset();
    cyc(MD); cyc(MD|ST); cyc(MD|LP);
    repeat (20) cyc(MD);
    #2 rst_n = 1'b0;
    #1 chk_zero("async rst");
    @(negedge clk_100Hz);
    m_reset();
    rst_n = 1'b1;
    cyc(MD);
    expect_t("post rst load", 32'h00010000, 1'b0, 1'b0);

    // Random traffic against the model.
    do_reset();
    md = 0;
    for (int n = 0; n < 5000; n++) begin
      v = NO;
      if ($urandom_range(199) == 0) md = ~md;
      if ($urandom_range(199) == 0) v |= CL;
      if ($urandom_range(99) < 4)   v |= SP;
      if ($urandom_range(99) < 8)   v |= ST;
      if ($urandom_range(99) < 12)  v |= LP;
      if ($urandom_range(99) < 10)  v |= RD;
      if ($urandom_range(99) < 5)   v |= SI;
      if ($urandom_range(99) < 5)   v |= MI;
      if ($urandom_range(99) < 4)   v |= HI;
      if (md) v |= MD;
      cyc(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
